// File: rtl/mem_stage.sv
// RV32I memory-access stage: passes ALU results through, runs load/store
// transactions on a ready/valid data bus and stalls upstream meanwhile.
module mem_stage #(
    parameter logic RESET_ADDR_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_fun,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_misaligned,
    output logic        mem_cmd_start,
    output logic        mem_cmd_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_cmd_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RDATA} state_t;

    state_t      state;
    logic [2:0]  fun_q;
    logic [1:0]  off_q;

    logic        is_mem;
    logic        is_word;
    logic        is_half;
    logic        misaligned;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [15:0] shifted;
    logic        ld_word;
    logic        ld_half;
    logic        ld_sign;
    logic [31:0] ld_data;
    logic        accept;
    logic        alu_done;
    logic        fault;
    logic        issue;
    logic        store_done;
    logic        load_done;
    logic        out_data_en;
    logic [31:0] out_data_d;

    // Decode, lane steering, load extraction and completion events.
    // Unused funct3 codes fall into the word case through in_fun[1].
    always_comb begin
        is_mem     = in_is_load | in_is_store;
        is_word    = in_fun[1];
        is_half    = ~in_fun[1] & in_fun[0];
        misaligned = 1'b0;
        st_mask    = 4'(4'b0001 << in_addr[1:0]);
        st_wdata   = {4{in_wdata[7:0]}};
        if (is_word) begin
            misaligned = (in_addr[1:0] != 2'b00);
            st_mask    = 4'b1111;
            st_wdata   = in_wdata;
        end else if (is_half) begin
            misaligned = in_addr[0];
            st_mask    = in_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata   = {2{in_wdata[15:0]}};
        end

        shifted = 16'(mem_rdata >> {off_q, 3'b000});
        ld_word = fun_q[1];
        ld_half = ~fun_q[1] & fun_q[0];
        ld_sign = ~fun_q[2];
        if (ld_word)
            ld_data = mem_rdata;
        else if (ld_half)
            ld_data = {{16{ld_sign & shifted[15]}}, shifted[15:0]};
        else
            ld_data = {{24{ld_sign & shifted[7]}}, shifted[7:0]};

        accept     = (state == IDLE) && in_valid;
        alu_done   = accept && !is_mem;
        fault      = accept && is_mem && misaligned;
        issue      = accept && is_mem && !misaligned;
        store_done = (state == ISSUE) && mem_cmd_ready && mem_cmd_write;
        load_done  = (state == WAIT_RDATA) && mem_rvalid;

        out_data_en = alu_done | fault | store_done | load_done;
        out_data_d  = 32'd0;
        if (alu_done)
            out_data_d = in_addr;
        else if (load_done)
            out_data_d = ld_data;
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            stall          <= 1'b0;
            out_valid      <= 1'b0;
            out_misaligned <= 1'b0;
            mem_cmd_start  <= 1'b0;
            mem_cmd_write  <= 1'b0;
            mem_wmask      <= 4'b0000;
            fun_q          <= 3'b000;
            off_q          <= 2'b00;
        end else begin
            out_valid      <= out_data_en;
            out_misaligned <= fault;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state         <= ISSUE;
                        stall         <= 1'b1;
                        mem_cmd_start <= 1'b1;
                        mem_cmd_write <= in_is_store & ~in_is_load;
                        mem_wmask     <= in_is_load ? 4'b0000 : st_mask;
                        fun_q         <= in_fun;
                        off_q         <= in_addr[1:0];
                    end
                end
                ISSUE: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_start <= 1'b0;
                        if (mem_cmd_write) begin
                            state <= IDLE;
                            stall <= 1'b0;
                        end else begin
                            state <= WAIT_RDATA;
                        end
                    end
                end
                WAIT_RDATA: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        stall <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    stall         <= 1'b0;
                    mem_cmd_start <= 1'b0;
                end
            endcase
        end
    end

    // Address/data registers; reset term is optional.
    if (RESET_ADDR_ZERO) begin : g_data_rst
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_data  <= 32'd0;
                mem_addr  <= 32'd0;
                mem_wdata <= 32'd0;
            end else begin
                if (out_data_en)
                    out_data <= out_data_d;
                if (issue) begin
                    mem_addr  <= {in_addr[31:2], 2'b00};
                    mem_wdata <= st_wdata;
                end
            end
        end
    end else begin : g_data_nrst
        always_ff @(posedge clk) begin
            if (out_data_en)
                out_data <= out_data_d;
            if (issue) begin
                mem_addr  <= {in_addr[31:2], 2'b00};
                mem_wdata <= st_wdata;
            end
        end
    end

endmodule
